// File: rtl/xidx_bitop_sequencer_pkg.sv
// Shared types and helpers for the indexed bit/rotate op sequencer.
// Holds the state encoding, opcode class constants and small decode helpers.
package xidx_bitop_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD,
    ST_EXEC,
    ST_WR
  } state_t;

  // Opcode class lives in opcode[7:6]; any class with bit 1 set is RES/SET.
  localparam logic [1:0] OPC_ROT    = 2'b00;
  localparam logic [1:0] OPC_BIT    = 2'b01;
  localparam logic [1:0] OPC_RESSET = 2'b10;

  function automatic logic is_bit_op(input logic [1:0] cls);
    return (cls == OPC_BIT);
  endfunction

  function automatic logic is_resset_op(input logic [1:0] cls);
    return ((cls & OPC_RESSET) == OPC_RESSET);
  endfunction

  function automatic logic is_low_lane_op(input logic [1:0] cls);
    return (cls == OPC_ROT) || (cls == OPC_BIT);
  endfunction

  // True when exactly one of the low n bits of v is set.
  function automatic logic onehot_ok(input logic [31:0] v, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if ((i < n) && v[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

  function automatic int beat_w(input int mem_len);
    return (mem_len > 1) ? $clog2(mem_len) : 1;
  endfunction

endpackage

// File: rtl/xidx_beat_counter.sv
// Beat counter shared by the read and write memory cycles.
// Counts 0..MEM_LEN-1, then holds on the last beat until ready.
module xidx_beat_counter
  import xidx_bitop_sequencer_pkg::*;
#(
  parameter int MEM_LEN = 3,
  parameter int BEAT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic              ready,
  output logic [BEAT_W-1:0] beat,
  output logic              last,
  output logic              accept
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MEM_LEN - 1);

  assign last   = (beat == LAST_BEAT);
  assign accept = run && last && ready;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      beat <= '0;
    end else if (run) begin
      if (!last) begin
        beat <= beat + 1'b1;
      end else if (ready) begin
        beat <= '0;
      end
    end
  end

endmodule

// File: rtl/xidx_bitop_sequencer.sv
// Self-timed sequencer for indexed bit/rotate/shift ops on (idx+d).
// Walks ADDR, read beats, EXEC and write beats, emitting one-cycle control strobes.
module xidx_bitop_sequencer
  import xidx_bitop_sequencer_pkg::*;
#(
  parameter  int MEM_LEN = 3,
  parameter  int N_IDX   = 2,
  localparam int STEP_W  = $clog2(2 * MEM_LEN + 3)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         opcode,
  input  logic [N_IDX-1:0]   idx_sel,
  input  logic               mem_ready,
  input  logic               abort,
  output logic               busy,
  output logic [STEP_W-1:0]  step,
  output logic               write_dtex,
  output logic [MEM_LEN-1:0] rd_strobe,
  output logic [MEM_LEN-1:0] wr_strobe,
  output logic               sel_ad_dtexdt,
  output logic               sel_ad_alu,
  output logic               sel_dt_dt,
  output logic               write_dt,
  output logic               alu_add,
  output logic               sel_opold_low,
  output logic [N_IDX-1:0]   sel_idx_high,
  output logic               alu_sel_dt_low,
  output logic               alu_sel_dt_high,
  output logic               enable_bit,
  output logic               done,
  output logic               set_cm1,
  output logic [N_IDX-1:0]   reset_prefix
);

  localparam int BEAT_W = beat_w(MEM_LEN);

  state_t             state, state_next;
  logic [7:0]         opc_q;
  logic [N_IDX-1:0]   idx_q;
  logic [BEAT_W-1:0]  beat;
  logic               beat_last;
  logic               beat_accept;
  logic               in_mem;
  logic               launch;
  logic [MEM_LEN-1:0] beat_onehot;
  logic [1:0]         cls;
  logic               unused_opc_bits;

  assign cls             = opc_q[7:6];
  assign unused_opc_bits = ^opc_q[5:0] ^ beat_last;
  assign in_mem          = (state == ST_RD) || (state == ST_WR);
  assign launch          = (state == ST_IDLE) && start && onehot_ok(32'(idx_sel), N_IDX);

  xidx_beat_counter #(
    .MEM_LEN(MEM_LEN),
    .BEAT_W (BEAT_W)
  ) u_beat (
    .clk   (clk),
    .reset (reset),
    .clear (abort || !in_mem),
    .run   (in_mem && !abort),
    .ready (mem_ready),
    .beat  (beat),
    .last  (beat_last),
    .accept(beat_accept)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      opc_q <= '0;
      idx_q <= '0;
    end else begin
      state <= state_next;
      if (launch) begin
        opc_q <= opcode;
        idx_q <= idx_sel;
      end
    end
  end

  // abort wins over everything but reset, including a pending mem_ready accept.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (launch) state_next = ST_ADDR;
      ST_ADDR: state_next = abort ? ST_IDLE : ST_RD;
      ST_RD: begin
        if (abort)            state_next = ST_IDLE;
        else if (beat_accept) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (abort || is_bit_op(cls)) state_next = ST_IDLE;
        else                         state_next = ST_WR;
      end
      ST_WR: begin
        if (abort || beat_accept) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < MEM_LEN; k++) begin
      beat_onehot[k] = (beat == BEAT_W'(k));
    end
  end

  always_comb begin
    busy            = (state != ST_IDLE);
    step            = '0;
    write_dtex      = 1'b0;
    rd_strobe       = '0;
    wr_strobe       = '0;
    sel_ad_dtexdt   = 1'b0;
    sel_ad_alu      = 1'b0;
    sel_dt_dt       = 1'b0;
    write_dt        = 1'b0;
    alu_add         = 1'b0;
    sel_opold_low   = 1'b0;
    sel_idx_high    = '0;
    alu_sel_dt_low  = 1'b0;
    alu_sel_dt_high = 1'b0;
    enable_bit      = 1'b0;
    done            = 1'b0;
    case (state)
      ST_ADDR: begin
        step          = STEP_W'(1);
        write_dtex    = 1'b1;
        alu_add       = 1'b1;
        sel_opold_low = 1'b1;
        sel_idx_high  = idx_q;
      end
      ST_RD: begin
        step          = STEP_W'(2) + STEP_W'(beat);
        sel_ad_dtexdt = 1'b1;
        rd_strobe     = beat_onehot;
        write_dt      = beat_accept;
      end
      ST_EXEC: begin
        step            = STEP_W'(MEM_LEN + 2);
        enable_bit      = 1'b1;
        alu_sel_dt_low  = is_low_lane_op(cls);
        alu_sel_dt_high = is_resset_op(cls);
        write_dt        = !is_bit_op(cls);
        done            = is_bit_op(cls) && !abort;
      end
      ST_WR: begin
        step          = STEP_W'(MEM_LEN + 3) + STEP_W'(beat);
        sel_ad_alu    = 1'b1;
        sel_dt_dt     = 1'b1;
        alu_add       = 1'b1;
        sel_opold_low = 1'b1;
        sel_idx_high  = idx_q;
        wr_strobe     = beat_onehot;
        done          = beat_accept;
      end
      default: ;
    endcase
    set_cm1      = done;
    reset_prefix = done ? idx_q : '0;
  end

endmodule

// File: tb/tb_xidx_bitop_sequencer.sv
// Directed self-checking bench for xidx_bitop_sequencer at MEM_LEN=3, N_IDX=2.
// Each scenario task drives stimulus and compares against hand-computed cycle tables.
module tb_xidx_bitop_sequencer;

  localparam int MEM_LEN = 3;
  localparam int N_IDX   = 2;
  localparam int STEP_W  = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         opcode;
  logic [N_IDX-1:0]   idx_sel;
  logic               mem_ready;
  logic               abort;
  logic               busy;
  logic [STEP_W-1:0]  step;
  logic               write_dtex;
  logic [MEM_LEN-1:0] rd_strobe;
  logic [MEM_LEN-1:0] wr_strobe;
  logic               sel_ad_dtexdt;
  logic               sel_ad_alu;
  logic               sel_dt_dt;
  logic               write_dt;
  logic               alu_add;
  logic               sel_opold_low;
  logic [N_IDX-1:0]   sel_idx_high;
  logic               alu_sel_dt_low;
  logic               alu_sel_dt_high;
  logic               enable_bit;
  logic               done;
  logic               set_cm1;
  logic [N_IDX-1:0]   reset_prefix;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [13:0] obs;
  logic [22:0] all_out;

  assign obs     = {step, rd_strobe, wr_strobe, write_dt, done, reset_prefix};
  assign all_out = {busy, write_dtex, rd_strobe, wr_strobe, sel_ad_dtexdt, sel_ad_alu,
                    sel_dt_dt, write_dt, alu_add, sel_opold_low, sel_idx_high,
                    alu_sel_dt_low, alu_sel_dt_high, enable_bit, done, set_cm1, reset_prefix};

  always #5 clk = ~clk;

  xidx_bitop_sequencer #(
    .MEM_LEN(MEM_LEN),
    .N_IDX  (N_IDX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .opcode         (opcode),
    .idx_sel        (idx_sel),
    .mem_ready      (mem_ready),
    .abort          (abort),
    .busy           (busy),
    .step           (step),
    .write_dtex     (write_dtex),
    .rd_strobe      (rd_strobe),
    .wr_strobe      (wr_strobe),
    .sel_ad_dtexdt  (sel_ad_dtexdt),
    .sel_ad_alu     (sel_ad_alu),
    .sel_dt_dt      (sel_dt_dt),
    .write_dt       (write_dt),
    .alu_add        (alu_add),
    .sel_opold_low  (sel_opold_low),
    .sel_idx_high   (sel_idx_high),
    .alu_sel_dt_low (alu_sel_dt_low),
    .alu_sel_dt_high(alu_sel_dt_high),
    .enable_bit     (enable_bit),
    .done           (done),
    .set_cm1        (set_cm1),
    .reset_prefix   (reset_prefix)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a start pulse in the current cycle; returns at cycle 1 (ADDR).
  task automatic launch(input logic [7:0] op, input logic [N_IDX-1:0] idx);
    start     = 1'b1;
    opcode    = op;
    idx_sel   = idx;
    mem_ready = 1'b1;
    abort     = 1'b0;
    #1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b1;
    opcode  = 8'hDE;
    idx_sel = 2'b01;
    tick();
    #1;
    n_cmp++;
    if (all_out !== 23'd0 || step !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got out=%h step=%0d want out=0 step=0", all_out, step);
    end
    tick();
    start = 1'b0;
    reset = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_set();
    logic [13:0] exp_tab [8] = '{
      {4'd1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd2, 3'b001, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd3, 3'b010, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd4, 3'b100, 3'b000, 1'b1, 1'b0, 2'b00},
      {4'd5, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00},
      {4'd6, 3'b000, 3'b001, 1'b0, 1'b0, 2'b00},
      {4'd7, 3'b000, 3'b010, 1'b0, 1'b0, 2'b00},
      {4'd8, 3'b000, 3'b100, 1'b0, 1'b1, 2'b01}
    };
    launch(8'hDE, 2'b01);
    for (int c = 1; c <= 8; c++) begin
      #1;
      n_cmp++;
      if (obs !== exp_tab[c-1]) begin
        n_fail++;
        $display("[TB] FAIL set_cycle%0d: got %h want %h", c, obs, exp_tab[c-1]);
      end
      if (c == 1) begin
        n_cmp++;
        if ({write_dtex, alu_add, sel_opold_low, sel_idx_high} !== 5'b11101) begin
          n_fail++;
          $display("[TB] FAIL set_addr_ctrl: got %b want 11101",
                   {write_dtex, alu_add, sel_opold_low, sel_idx_high});
        end
      end
      if (c == 2) begin
        n_cmp++;
        if ({sel_ad_dtexdt, sel_ad_alu} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL set_rd_ctrl: got %b want 10", {sel_ad_dtexdt, sel_ad_alu});
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({enable_bit, alu_sel_dt_low, alu_sel_dt_high} !== 3'b101) begin
          n_fail++;
          $display("[TB] FAIL set_exec_ctrl: got %b want 101",
                   {enable_bit, alu_sel_dt_low, alu_sel_dt_high});
        end
      end
      if (c == 6) begin
        n_cmp++;
        if ({sel_ad_alu, sel_dt_dt, alu_add, sel_opold_low, sel_idx_high} !== 6'b111101) begin
          n_fail++;
          $display("[TB] FAIL set_wr_ctrl: got %b want 111101",
                   {sel_ad_alu, sel_dt_dt, alu_add, sel_opold_low, sel_idx_high});
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (set_cm1 !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL set_cm1: got %b want 1", set_cm1);
        end
      end
      tick();
    end
    #1;
    n_cmp++;
    if (busy !== 1'b0 || obs !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL set_after_done: got busy=%b obs=%h want busy=0 obs=0", busy, obs);
    end
  endtask

  task automatic test_bit();
    logic [13:0] exp_tab [5] = '{
      {4'd1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd2, 3'b001, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd3, 3'b010, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd4, 3'b100, 3'b000, 1'b1, 1'b0, 2'b00},
      {4'd5, 3'b000, 3'b000, 1'b0, 1'b1, 2'b10}
    };
    launch(8'h7E, 2'b10);
    for (int c = 1; c <= 5; c++) begin
      #1;
      n_cmp++;
      if (obs !== exp_tab[c-1]) begin
        n_fail++;
        $display("[TB] FAIL bit_cycle%0d: got %h want %h", c, obs, exp_tab[c-1]);
      end
      if (c == 1) begin
        n_cmp++;
        if (sel_idx_high !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL bit_idx_high: got %b want 10", sel_idx_high);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({enable_bit, alu_sel_dt_low, alu_sel_dt_high} !== 3'b110) begin
          n_fail++;
          $display("[TB] FAIL bit_exec_ctrl: got %b want 110",
                   {enable_bit, alu_sel_dt_low, alu_sel_dt_high});
        end
      end
      tick();
    end
    #1;
    n_cmp++;
    if (busy !== 1'b0 || wr_strobe !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL bit_no_write: got busy=%b wr=%b want busy=0 wr=000", busy, wr_strobe);
    end
  endtask

  task automatic test_wait();
    logic        mr_tab [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [13:0] exp_tab [11] = '{
      {4'd1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd2, 3'b001, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd3, 3'b010, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd4, 3'b100, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd4, 3'b100, 3'b000, 1'b0, 1'b0, 2'b00},
      {4'd4, 3'b100, 3'b000, 1'b1, 1'b0, 2'b00},
      {4'd5, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00},
      {4'd6, 3'b000, 3'b001, 1'b0, 1'b0, 2'b00},
      {4'd7, 3'b000, 3'b010, 1'b0, 1'b0, 2'b00},
      {4'd8, 3'b000, 3'b100, 1'b0, 1'b0, 2'b00},
      {4'd8, 3'b000, 3'b100, 1'b0, 1'b1, 2'b01}
    };
    launch(8'h06, 2'b01);
    for (int c = 1; c <= 11; c++) begin
      mem_ready = mr_tab[c-1];
      if (c == 11) begin
        start   = 1'b1;
        opcode  = 8'h7E;
        idx_sel = 2'b10;
      end
      #1;
      n_cmp++;
      if (obs !== exp_tab[c-1]) begin
        n_fail++;
        $display("[TB] FAIL wait_cycle%0d: got %h want %h", c, obs, exp_tab[c-1]);
      end
      if (c == 7) begin
        n_cmp++;
        if ({alu_sel_dt_low, alu_sel_dt_high} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL wait_exec_lane: got %b want 10", {alu_sel_dt_low, alu_sel_dt_high});
        end
      end
      tick();
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_on_done: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort();
    launch(8'hDE, 2'b01);
    for (int c = 1; c < 7; c++) tick();
    abort = 1'b1;
    #1;
    n_cmp++;
    if ({wr_strobe, done, reset_prefix} !== 6'b010000) begin
      n_fail++;
      $display("[TB] FAIL abort_wr1: got %b want 010000", {wr_strobe, done, reset_prefix});
    end
    tick();
    abort = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || obs !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: got busy=%b obs=%h want busy=0 obs=0", busy, obs);
    end
    tick();
    launch(8'h7E, 2'b10);
    for (int c = 1; c < 5; c++) tick();
    #1;
    n_cmp++;
    if (obs !== {4'd5, 3'b000, 3'b000, 1'b0, 1'b1, 2'b10}) begin
      n_fail++;
      $display("[TB] FAIL abort_relaunch: got %h want %h", obs,
               {4'd5, 3'b000, 3'b000, 1'b0, 1'b1, 2'b10});
    end
    tick();
    launch(8'h06, 2'b01);
    for (int c = 1; c < 4; c++) tick();
    abort     = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (write_dt !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_beats_ready: got write_dt=%b want 0", write_dt);
    end
    tick();
    abort = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || step !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_rd_idle: got busy=%b step=%0d want 0/0", busy, step);
    end
  endtask

  task automatic test_bad_idx();
    logic [1:0] bad [2] = '{2'b11, 2'b00};
    for (int i = 0; i < 2; i++) begin
      start   = 1'b1;
      opcode  = 8'hDE;
      idx_sel = bad[i];
      #1;
      tick();
      start = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || step !== 4'd0) begin
        n_fail++;
        $display("[TB] FAIL bad_idx_%b: got busy=%b step=%0d want 0/0", bad[i], busy, step);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    launch(8'h06, 2'b01);
    tick();
    tick();
    start   = 1'b1;
    opcode  = 8'h7E;
    idx_sel = 2'b10;
    #1;
    tick();
    start = 1'b0;
    tick();
    #1;
    n_cmp++;
    if ({enable_bit, alu_sel_dt_low, alu_sel_dt_high, write_dt, done} !== 5'b11010) begin
      n_fail++;
      $display("[TB] FAIL busy_start_exec: got %b want 11010",
               {enable_bit, alu_sel_dt_low, alu_sel_dt_high, write_dt, done});
    end
    tick();
    #1;
    n_cmp++;
    if (wr_strobe !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL busy_start_wr0: got %b want 001", wr_strobe);
    end
    tick();
    tick();
    #1;
    n_cmp++;
    if (obs !== {4'd8, 3'b000, 3'b100, 1'b0, 1'b1, 2'b01}) begin
      n_fail++;
      $display("[TB] FAIL busy_start_done: got %h want %h", obs,
               {4'd8, 3'b000, 3'b100, 1'b0, 1'b1, 2'b01});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    launch(8'hDE, 2'b01);
    tick();
    tick();
    #1;
    n_cmp++;
    if (rd_strobe !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_rd1: got %b want 010", rd_strobe);
    end
    reset = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (all_out !== 23'd0 || step !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: got out=%h step=%0d want 0/0", all_out, step);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    opcode    = 8'h00;
    idx_sel   = '0;
    mem_ready = 1'b1;
    abort     = 1'b0;
    test_reset();
    test_set();
    test_bit();
    test_wait();
    tick();
    test_abort();
    tick();
    test_bad_idx();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
